matmul_out_writer: RTL and testbench

Output-side stage that sits directly downstream of the matrix-multiply top level. It captures each finished BLOCK_SIZE×BLOCK_SIZE output tile, qualified by the accumulator-done strobe, into a small FIFO. It then writes the tiles into the output BRAM through port A, generating tile-ordered addresses, and signals frame completion after all ROW_SIZE_MAT_C×COL_SIZE_MAT_C tiles are written.

---
 rtl/matmul_out_writer.sv | 205 ++++++++++++++++++++
 tb/tb_matmul_out_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_out_writer.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_out_writer
//  Description : Output-side stage behind the matrix-multiply top level.
//                Finished BLOCK_SIZE x BLOCK_SIZE tiles, qualified by the
//                accumulator-done strobe, are captured into a small FIFO and
//                then written into the output BRAM (port A) at tile-ordered
//                addresses.  A done pulse marks the end of the frame.
//
//  Ports       : clk           - single clock, rising edge
//                rst_n         - synchronous active-low reset
//                start         - begins a frame (honoured only when idle)
//                transpose     - sampled with start; column-major tile layout
//                in_valid      - tile strobe from the multiply stage
//                in_data       - tile contents
//                wr_stall      - BRAM port A busy, blocks a write
//                ob_ena        - BRAM port A enable
//                ob_wea        - BRAM byte write enable (8'hFF on a write)
//                ob_addra      - BRAM write address
//                ob_dina       - BRAM write data
//                busy          - frame in progress (RUN or DRAIN)
//                done          - one-cycle frame-complete pulse
//                overflow      - sticky, a tile was dropped
//                tiles_written - tiles written this frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_out_writer #(
    parameter int WIDTH             = 16,
    parameter int BLOCK_SIZE        = 2,
    parameter int CHUNK_SIZE        = 4,
    parameter int I_OUTER_DIMENSION = 6,
    parameter int W_OUTER_DIMENSION = 6,
    parameter int ROW_SIZE_MAT_C    = I_OUTER_DIMENSION / BLOCK_SIZE,
    parameter int COL_SIZE_MAT_C    = W_OUTER_DIMENSION / BLOCK_SIZE,
    parameter int MAX_FLAG          = ROW_SIZE_MAT_C * COL_SIZE_MAT_C,
    parameter int FIFO_DEPTH        = 4,
    parameter int ADDR_WIDTH        = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             transpose,
    input  logic                             in_valid,
    input  logic [WIDTH*CHUNK_SIZE-1:0]      in_data,
    input  logic                             wr_stall,
    output logic                             ob_ena,
    output logic [7:0]                       ob_wea,
    output logic [ADDR_WIDTH-1:0]            ob_addra,
    output logic [WIDTH*CHUNK_SIZE-1:0]      ob_dina,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic [$clog2(MAX_FLAG+1)-1:0]    tiles_written
);

    localparam int DATA_W = WIDTH * CHUNK_SIZE;
    localparam int CNT_W  = $clog2(MAX_FLAG + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;

    logic [DATA_W-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]         count_q;

    logic [CNT_W-1:0]       acc_q;      // tiles accepted, including dropped ones
    logic [CNT_W-1:0]       wcol_q, wrow_q;
    logic [CNT_W-1:0]       tiles_q;
    logic                   transpose_q;
    logic                   overflow_q;

    logic                   ob_ena_q;
    logic [ADDR_WIDTH-1:0]  ob_addra_q;
    logic [DATA_W-1:0]      ob_dina_q;

    logic                   start_ok;
    logic                   active;
    logic                   fifo_empty, fifo_full;
    logic                   take, do_push, do_pop, drop, last_accept;
    logic [ADDR_WIDTH-1:0]  addr_norm, addr_trans, addr_next;

    assign start_ok    = (state_q == S_IDLE) && start;
    assign active      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));

    assign do_pop      = active && !fifo_empty && !wr_stall;
    assign take        = (state_q == S_RUN) && in_valid;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign do_push     = take && (!fifo_full || do_pop);
    assign drop        = take && fifo_full && !do_pop;
    assign last_accept = take && (acc_q == CNT_W'(MAX_FLAG - 1));

    assign addr_norm  = ADDR_WIDTH'(wrow_q) * ADDR_WIDTH'(COL_SIZE_MAT_C) + ADDR_WIDTH'(wcol_q);
    assign addr_trans = ADDR_WIDTH'(wcol_q) * ADDR_WIDTH'(ROW_SIZE_MAT_C) + ADDR_WIDTH'(wrow_q);
    assign addr_next  = transpose_q ? addr_trans : addr_norm;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)       state_d = S_RUN;
            S_RUN:   if (last_accept) state_d = S_DRAIN;
            // The FIFO empties on the edge that issues the final write, so
            // DONE follows the cycle in which that write is visible.
            S_DRAIN: if (fifo_empty)  state_d = S_DONE;
            S_DONE:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Tile storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            wcol_q      <= '0;
            wrow_q      <= '0;
            tiles_q     <= '0;
            transpose_q <= 1'b0;
            overflow_q  <= 1'b0;
            ob_ena_q    <= 1'b0;
            ob_addra_q  <= '0;
            ob_dina_q   <= '0;
        end else begin
            state_q  <= state_d;
            ob_ena_q <= do_pop;

            if (do_pop) begin
                ob_addra_q <= addr_next;
                ob_dina_q  <= fifo_mem_q[rd_ptr_q];
            end

            if (start_ok) begin
                transpose_q <= transpose;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                acc_q       <= '0;
                wcol_q      <= '0;
                wrow_q      <= '0;
                tiles_q     <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end

                unique case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                    2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                    default: count_q <= count_q;
                endcase

                if (take) begin
                    acc_q <= acc_q + CNT_W'(1);
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end

                if (do_pop) begin
                    tiles_q <= tiles_q + CNT_W'(1);
                    if (wcol_q == CNT_W'(COL_SIZE_MAT_C - 1)) begin
                        wcol_q <= '0;
                        wrow_q <= wrow_q + CNT_W'(1);
                    end else begin
                        wcol_q <= wcol_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign ob_ena        = ob_ena_q;
    assign ob_wea        = ob_ena_q ? 8'hFF : 8'h00;
    assign ob_addra      = ob_addra_q;
    assign ob_dina       = ob_dina_q;
    assign busy          = active;
    assign done          = (state_q == S_DONE);
    assign overflow      = overflow_q;
    assign tiles_written = tiles_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_out_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_out_writer
//  Description : Self-checking bench for matmul_out_writer.  A queue-based
//                behavioural model predicts every output each cycle; directed
//                frames add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_out_writer;

    localparam int WIDTH      = 16;
    localparam int CHUNK      = 4;
    localparam int DW         = WIDTH * CHUNK;
    localparam int ROWS       = 3;
    localparam int COLS       = 3;
    localparam int MAX_FLAG   = ROWS * COLS;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = 12;
    localparam int CW         = $clog2(MAX_FLAG + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          transpose;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          wr_stall;
    logic          ob_ena;
    logic [7:0]    ob_wea;
    logic [AW-1:0] ob_addra;
    logic [DW-1:0] ob_dina;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] tiles_written;

    matmul_out_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .transpose     (transpose),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .wr_stall      (wr_stall),
        .ob_ena        (ob_ena),
        .ob_wea        (ob_wea),
        .ob_addra      (ob_addra),
        .ob_dina       (ob_dina),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .tiles_written (tiles_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] tile(input int i);
        logic [DW-1:0] v;
        v = {16'(16'hA000 + i), 16'(16'h0B00 + i * 3), 16'(16'h00C0 + i * 5), 16'(i + 1)};
        return v;
    endfunction

    // k-th write of a frame lands at tile (k / COLS, k % COLS)
    function automatic int addr_of(input int k, input bit tr);
        int r, c;
        r = k / COLS;
        c = k % COLS;
        return tr ? (c * ROWS + r) : (r * COLS + c);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 run, 2 drain, 3 done
    // ------------------------------------------------------------------
    int            m_phase = 0;
    logic [DW-1:0] mq[$];
    int            m_acc   = 0;
    int            m_wr    = 0;
    bit            m_trans = 0;
    bit            m_ovf   = 0;
    bit            m_ena   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            mq.delete();
            m_acc   = 0;
            m_wr    = 0;
            m_trans = 0;
            m_ovf   = 0;
            m_ena   = 0;
            m_addr  = '0;
            m_data  = '0;
        end else begin
            bit pop;
            bit empty_now;
            int ph;
            ph        = m_phase;
            empty_now = (mq.size() == 0);
            pop       = (ph == 1 || ph == 2) && !empty_now && !wr_stall;
            case (ph)
                0: if (start) begin
                       m_phase = 1;
                       mq.delete();
                       m_acc   = 0;
                       m_wr    = 0;
                       m_ovf   = 0;
                       m_trans = transpose;
                   end
                2: if (m_ena && empty_now) m_phase = 3;
                3: m_phase = 0;
                default: ;
            endcase
            m_ena = pop;
            if (pop) begin
                m_data = mq.pop_front();
                m_addr = AW'(addr_of(m_wr, m_trans));
                m_wr   = m_wr + 1;
            end
            if (ph == 1 && in_valid) begin
                m_acc = m_acc + 1;
                if (mq.size() < FIFO_DEPTH) mq.push_back(in_data);
                else m_ovf = 1;
                if (m_acc == MAX_FLAG) m_phase = 2;
            end
        end
    end

    // Logs of observed writes for the directed literal checks
    int            wl_addr[$];
    logic [DW-1:0] wl_data[$];
    int            wl_cyc[$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("ob_ena",        64'(ob_ena),        64'(m_ena));
            chk("ob_wea",        64'(ob_wea),        m_ena ? 64'hFF : 64'h0);
            chk("ob_addra",      64'(ob_addra),      64'(m_addr));
            chk("ob_dina",       64'(ob_dina),       64'(m_data));
            chk("busy",          64'(busy),          64'(m_phase == 1 || m_phase == 2));
            chk("done",          64'(done),          64'(m_phase == 3));
            chk("overflow",      64'(overflow),      64'(m_ovf));
            chk("tiles_written", 64'(tiles_written), 64'(m_wr));
            if (ob_ena) begin
                wl_addr.push_back(int'(ob_addra));
                wl_data.push_back(ob_dina);
                wl_cyc.push_back(cyc);
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input bit tr);
        transpose = tr;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        transpose = 1'b0;
    endtask

    task automatic send(input int i, input int gap);
        in_valid = 1'b1;
        in_data  = tile(i);
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n = n + 1;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_writes(input string tag, input int n, input bit tr);
        chk({tag, "_nwrites"}, 64'(wl_addr.size()), 64'(n));
        if (wl_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_addr"}, 64'(wl_addr[i]), 64'(addr_of(i, tr)));
                chk({tag, "_data"}, 64'(wl_data[i]), 64'(tile(i)));
            end
        end
    endtask

    int exp_tr[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

    initial begin
        int first;
        rst_n     = 1'b0;
        start     = 1'b0;
        transpose = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        wr_stall  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ob_ena",   64'(ob_ena),        64'd0);
        chk("rst_ob_wea",   64'(ob_wea),        64'd0);
        chk("rst_ob_addra", 64'(ob_addra),      64'd0);
        chk("rst_ob_dina",  64'(ob_dina),       64'd0);
        chk("rst_busy",     64'(busy),          64'd0);
        chk("rst_done",     64'(done),          64'd0);
        chk("rst_overflow", 64'(overflow),      64'd0);
        chk("rst_tiles",    64'(tiles_written), 64'd0);
        rst_n = 1'b1;
        tick();

        // Normal layout, spaced tiles
        clear_logs();
        start_frame(1'b0);
        for (int i = 0; i < 9; i++) send(i, 2);
        wait_done();
        tick();
        check_writes("norm", 9, 1'b0);
        for (int i = 0; i < wl_addr.size(); i++) chk("norm_lit_addr", 64'(wl_addr[i]), 64'(i));
        chk("norm_done_cnt", 64'(done_cnt),      64'd1);
        chk("norm_tiles",    64'(tiles_written), 64'd9);
        chk("norm_overflow", 64'(overflow),      64'd0);

        // Transposed layout
        clear_logs();
        start_frame(1'b1);
        for (int i = 0; i < 9; i++) send(i, 2);
        wait_done();
        tick();
        check_writes("trans", 9, 1'b1);
        for (int i = 0; i < wl_addr.size() && i < 9; i++)
            chk("trans_lit_addr", 64'(wl_addr[i]), 64'(exp_tr[i]));
        chk("trans_done_cnt", 64'(done_cnt), 64'd1);

        // Stall for 10 cycles under a back-to-back burst: 4 buffered, 5 dropped
        clear_logs();
        start_frame(1'b0);
        wr_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = tile(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        wr_stall = 1'b0;
        wait_done();
        tick();
        check_writes("stall", 4, 1'b0);
        chk("stall_overflow", 64'(overflow),      64'd1);
        chk("stall_tiles",    64'(tiles_written), 64'd4);
        chk("stall_done_cnt", 64'(done_cnt),      64'd1);

        // Back-to-back burst, no stall
        clear_logs();
        start_frame(1'b0);
        first = cyc;
        for (int i = 0; i < 9; i++) send(i, 0);
        wait_done();
        tick();
        check_writes("b2b", 9, 1'b0);
        if (wl_cyc.size() == 9) begin
            chk("b2b_first_ena", 64'(wl_cyc[0]), 64'(first + 2));
            chk("b2b_last_ena",  64'(wl_cyc[8]), 64'(first + 10));
        end
        chk("b2b_done_cnt", 64'(done_cnt), 64'd1);

        // Reset mid-frame after 5 tiles
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) send(i, 2);
        rst_n = 1'b0;
        tick();
        chk("mid_ob_ena",   64'(ob_ena),        64'd0);
        chk("mid_ob_wea",   64'(ob_wea),        64'd0);
        chk("mid_ob_addra", 64'(ob_addra),      64'd0);
        chk("mid_ob_dina",  64'(ob_dina),       64'd0);
        chk("mid_busy",     64'(busy),          64'd0);
        chk("mid_overflow", 64'(overflow),      64'd0);
        chk("mid_tiles",    64'(tiles_written), 64'd0);
        rst_n = 1'b1;
        clear_logs();
        start_frame(1'b0);
        for (int i = 0; i < 9; i++) send(i, 2);
        wait_done();
        tick();
        check_writes("post_rst", 9, 1'b0);
        if (wl_addr.size() > 0) chk("post_rst_first_addr", 64'(wl_addr[0]), 64'd0);

        // Ignored controls: in_valid in IDLE, start in RUN and in DONE
        clear_logs();
        for (int i = 0; i < 3; i++) send(i, 0);
        chk("idle_nwrites", 64'(wl_addr.size()), 64'd0);
        chk("idle_overflow", 64'(overflow),      64'd0);
        chk("idle_busy",     64'(busy),          64'd0);
        start_frame(1'b0);
        send(0, 2);
        send(1, 2);
        transpose = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        transpose = 1'b0;
        chk("run_start_busy",  64'(busy),          64'd1);
        chk("run_start_tiles", 64'(tiles_written), 64'd2);
        for (int i = 2; i < 9; i++) send(i, 2);
        wait_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("done_start_busy", 64'(busy), 64'd0);
        check_writes("ign", 9, 1'b0);
        for (int i = 0; i < wl_addr.size(); i++) chk("ign_lit_addr", 64'(wl_addr[i]), 64'(i));
        chk("ign_overflow", 64'(overflow), 64'd0);
        chk("ign_done_cnt", 64'(done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
